// File: rtl/pmod_serial_tx.sv
// pmod_serial_tx: LSB-first serialiser for the inter-board PMOD link with a frame qualifier and mid-bit strobe.
// Define PMOD_TX_PARITY_EN to append an even-parity bit period after the payload.
module pmod_serial_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BIT_CYCLES = 2,
  parameter int GAP_BITS   = 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_TX_DV,
  input  logic [DATA_WIDTH-1:0] i_TX_Byte,
  output logic                  o_TX_Ready,
  output logic                  o_TX_Busy,
  output logic                  o_TX_Done,
  output logic                  o_PMOD_Data,
  output logic                  o_PMOD_Frame,
  output logic                  o_PMOD_Strobe
);
  localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int MAXB = (DATA_WIDTH > GAP_BITS) ? DATA_WIDTH : GAP_BITS;
  localparam int BW   = $clog2(MAXB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] STB_PRE  = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [BW-1:0] DAT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] GAP_LAST = BW'(GAP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_GAP} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] hold, shift, shift_nx;
  logic                  framed, period_end, gap_last, load;
`ifdef PMOD_TX_PARITY_EN
  logic                  parity;
`endif

  assign shift_nx   = shift >> 1;
  assign framed     = (state == S_START) || (state == S_DATA) || (state == S_PARITY);
  assign period_end = (cnt == CNT_LAST);
  assign gap_last   = (state == S_GAP) && period_end && (bit_idx == GAP_LAST);
  // Holding register is full exactly while o_TX_Ready is low.
  assign load       = !o_TX_Ready && ((state == S_IDLE) || gap_last);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      hold          <= '0;
      shift         <= '0;
      o_TX_Ready    <= 1'b1;
      o_TX_Busy     <= 1'b0;
      o_TX_Done     <= 1'b0;
      o_PMOD_Data   <= 1'b1;
      o_PMOD_Frame  <= 1'b0;
      o_PMOD_Strobe <= 1'b0;
`ifdef PMOD_TX_PARITY_EN
      parity        <= 1'b0;
`endif
    end else begin
      o_TX_Done     <= gap_last;
      // Strobe lands when the registered count reaches BIT_CYCLES/2.
      o_PMOD_Strobe <= framed && (cnt == STB_PRE);
      if (i_TX_DV && o_TX_Ready) begin
        hold       <= i_TX_Byte;
        o_TX_Ready <= 1'b0;
      end
      if (load) begin
        state        <= S_START;
        cnt          <= '0;
        bit_idx      <= '0;
        shift        <= hold;
        o_TX_Ready   <= 1'b1;
        o_TX_Busy    <= 1'b1;
        o_PMOD_Data  <= 1'b0;
        o_PMOD_Frame <= 1'b1;
`ifdef PMOD_TX_PARITY_EN
        parity       <= ^hold;
`endif
      end else if (state != S_IDLE) begin
        cnt <= period_end ? '0 : cnt + 1'b1;
        if (period_end) begin
          case (state)
            S_START: begin
              state       <= S_DATA;
              o_PMOD_Data <= shift[0];
            end
            S_DATA: begin
              if (bit_idx != DAT_LAST) begin
                bit_idx     <= bit_idx + 1'b1;
                shift       <= shift_nx;
                o_PMOD_Data <= shift_nx[0];
              end else begin
`ifdef PMOD_TX_PARITY_EN
                state        <= S_PARITY;
                o_PMOD_Data  <= parity;
`else
                state        <= S_GAP;
                bit_idx      <= '0;
                o_PMOD_Data  <= 1'b1;
                o_PMOD_Frame <= 1'b0;
`endif
              end
            end
`ifdef PMOD_TX_PARITY_EN
            S_PARITY: begin
              state        <= S_GAP;
              bit_idx      <= '0;
              o_PMOD_Data  <= 1'b1;
              o_PMOD_Frame <= 1'b0;
            end
`endif
            S_GAP: begin
              if (bit_idx != GAP_LAST) begin
                bit_idx <= bit_idx + 1'b1;
              end else begin
                state     <= S_IDLE;
                bit_idx   <= '0;
                o_TX_Busy <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/pmod_serial_tx.md
Name: pmod_serial_tx

Overview:
Serialising transmitter for the inter-board PMOD link.
- Takes parallel words from local logic and shifts them out LSB-first on a single data line.
- Adds a framing qualifier and a mid-bit sample strobe.
- Sits directly upstream of the PMOD receiver/7-segment display stage on the other board.
- A one-entry holding register lets the next word be queued while the current frame is on the wire.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (1..16).
- BIT_CYCLES, 2, clocks per bit period (>=2; values <2 unsupported).
- GAP_BITS, 1, idle bit periods after each frame (>=1).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_TX_DV  in  1  word-valid from producer.
- i_TX_Byte  in  DATA_WIDTH  word to send.
- o_TX_Ready  out  1  holding register empty; word accepted when i_TX_DV && o_TX_Ready at a rising edge.
- o_TX_Busy  out  1  FSM not in IDLE.
- o_TX_Done  out  1  one-cycle pulse at the end of each frame's gap.
- o_PMOD_Data  out  1  serial data line (PMOD pin 1).
- o_PMOD_Frame  out  1  high during START/DATA/PARITY bit periods.
- o_PMOD_Strobe  out  1  one-cycle pulse at the mid-point of every framed bit period.

Behaviour:
- Reset (async assert, sync release):
  - o_PMOD_Data=1, o_PMOD_Frame=0, o_PMOD_Strobe=0.
  - o_TX_Ready=1, o_TX_Busy=0, o_TX_Done=0.
  - Holding register cleared, FSM=IDLE.
- All outputs registered.
- Accept:
  - i_TX_DV && o_TX_Ready at edge E captures i_TX_Byte into hold.
  - hold_full=1 and o_TX_Ready=0 after E.
  - i_TX_DV while o_TX_Ready=0 is ignored; no capture, no error.
- Load:
  - Occurs when FSM is in IDLE, or at the last GAP cycle, and hold_full=1.
  - Copies hold into the shift register and clears hold_full at that edge.
  - o_TX_Ready returns to 1 the cycle after the load.
  - Accept and load never coincide (o_TX_Ready=0 while hold_full=1).
- Bit timer: counts 0..BIT_CYCLES-1 within each bit period. o_PMOD_Strobe=1 when count==BIT_CYCLES/2 in framed states only.
- FSM:
  - IDLE: Data=1, Frame=0. Goes to START on load.
  - START: 1 bit period, Data=0, Frame=1. Goes to DATA.
  - DATA: DATA_WIDTH periods, Data=shift[0], shift right each period end, Frame=1. Goes to PARITY if enabled, else GAP.
  - PARITY: see Optional Feature.
  - GAP: GAP_BITS periods, Data=1, Frame=0. On the last cycle pulse o_TX_Done. If hold_full, load and go to START with no extra idle cycle; else go to IDLE.
- Latency: for an accept at edge E with FSM idle, load happens at E+1. Frame=1 and Data=0 are visible from E+1 for BIT_CYCLES cycles.
- Frame length: (1+DATA_WIDTH[+1]) x BIT_CYCLES clocks with Frame high, then GAP_BITS x BIT_CYCLES clocks low. Back-to-back period is (1+DATA_WIDTH[+1]+GAP_BITS) x BIT_CYCLES.
- Counters wrap only at their defined terminal values. There are no free-running overflows.
- Reset mid-frame: outputs return to idle values immediately. In-flight and held words are discarded. No o_TX_Done pulse.

Optional Feature:
- Macro: PMOD_TX_PARITY_EN.
- Defined: a PARITY state of one bit period follows DATA. Data = even parity (XOR of all payload bits). Frame=1 and the strobe fires.
- Undefined: no PARITY state; DATA goes straight to GAP. The frame is one bit period shorter.

Test Plan:
1. Defaults (parity off), single word:
   - Stimulus: send 0xA5 from idle.
   - Data per bit period: 0 (start), then 1,0,1,0,0,1,0,1.
   - Frame high for exactly 18 clocks; 9 strobes, each at count 1.
   - o_TX_Done pulses once, 20 clocks after load.
2. Back-to-back:
   - Stimulus: send 0x01, then offer 0xFF during the first frame's DATA state.
   - 0xFF is accepted and o_TX_Ready drops.
   - Second START begins the cycle after the first gap ends.
   - Frame starts are 20 clocks apart; two o_TX_Done pulses.
3. Backpressure:
   - Stimulus: with hold full, hold i_TX_DV=1 with 0x3C for 10 cycles.
   - 0x3C is not captured until o_TX_Ready rises. It is then sent exactly once.
4. Async reset:
   - Stimulus: assert i_Rst_L=0 during DATA bit 4 of 0x5A while 0x77 is held.
   - Outputs go to idle values immediately, not at the next clock edge. Nothing is transmitted after release until a new accept.
5. PMOD_TX_PARITY_EN defined:
   - Send 0xA5: parity bit 0, Frame high 20 clocks.
   - Send 0x07: parity bit 1.
6. Non-default parameters:
   - Stimulus: BIT_CYCLES=4, GAP_BITS=2, send 0x80.
   - Each bit lasts 4 clocks; strobe at count 2.
   - Data bits are seven 0s then a 1; gap lasts 8 clocks before o_TX_Done.
